// File: rtl/frame_sched.sv
// frame_sched -- sequences one full-frame sweep of the shared metaball datapath.
//
// For every display pixel (x outer, y inner) the block presents the sample
// point (p_x, p_y) and ROM address, strobes all metaballs, waits for every
// valid, then thresholds the summed field. The result is written as colour or
// black into the top (idx < 1024) or bottom frame buffer. One buffer swap is
// issued per completed frame.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   frame_req    start-frame strobe; one request is queued while busy
//   mb_vld       per-metaball result valid
//   sum          summed metaball field (unsigned)
//   colour       colour ROM data for rom_addr (1-cycle latency)
//   rom_addr     pixel index idx = x*ROWS + y
//   px_stb       start-calculation strobe to all metaballs
//   p_x, p_y     sample point, fixed point with 15 fractional bits
//   w_en         buffer write strobe
//   w_mask       0 = top buffer, 1 = bottom buffer
//   w_addr, din  buffer write address / data
//   swap_en      buffer swap strobe
//   busy         frame in progress
//   frame_done   end-of-frame pulse
//   timeout_err  sticky, set when any pixel times out waiting for valids
module frame_sched #(
  parameter int unsigned N_MB    = 3,
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 64,
  parameter logic [31:0] STEP    = 32'h0000_8000,
  parameter logic [31:0] THRESH  = 32'h0000_8000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_req,
  input  logic [N_MB-1:0] mb_vld,
  input  logic [31:0]     sum,
  input  logic [11:0]     colour,
  output logic [10:0]     rom_addr,
  output logic            px_stb,
  output logic [31:0]     p_x,
  output logic [31:0]     p_y,
  output logic            w_en,
  output logic            w_mask,
  output logic [9:0]      w_addr,
  output logic [11:0]     din,
  output logic            swap_en,
  output logic            busy,
  output logic            frame_done,
  output logic            timeout_err
);

  localparam int unsigned YW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  localparam logic [10:0]    LAST_IDX  = 11'(COLS * ROWS - 1);
  localparam logic [YW-1:0]  LAST_Y    = YW'(ROWS - 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_SWAP
  } state_t;

  state_t         r_state;
  logic [10:0]    r_idx;
  logic [YW-1:0]  r_y;
  logic [31:0]    r_px;
  logic [31:0]    r_py;
  logic           r_pend;
  logic [WCW-1:0] r_wcnt;
  logic           r_px_stb;
  logic           r_w_en;
  logic [11:0]    r_din;
  logic           r_swap;
  logic           r_done;
  logic           r_busy;
  logic           r_terr;

  logic w_all_vld;
  logic w_lit;

  assign w_all_vld = &mb_vld;
  assign w_lit     = (sum >= THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_y      <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_pend   <= 1'b0;
      r_wcnt   <= '0;
      r_px_stb <= 1'b0;
      r_w_en   <= 1'b0;
      r_din    <= '0;
      r_swap   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_px_stb <= 1'b0;
      r_w_en   <= 1'b0;
      r_swap   <= 1'b0;
      r_done   <= 1'b0;

      // One-deep request queue; covers the SWAP cycle as well.
      if (frame_req && (r_state != S_IDLE)) begin
        r_pend <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (frame_req || r_pend) begin
            r_pend   <= 1'b0;
            r_idx    <= '0;
            r_y      <= '0;
            r_px     <= '0;
            r_py     <= '0;
            r_busy   <= 1'b1;
            r_px_stb <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // r_wcnt == 0 marks the first WAIT cycle, where the valids are
          // still stale from the previous pixel. The write data is captured
          // here, from the same cycle that proves all results valid; the ROM
          // address has been stable since ISSUE, so colour is already current.
          if ((r_wcnt != '0) && w_all_vld) begin
            r_din   <= w_lit ? colour : '0;
            r_w_en  <= 1'b1;
            r_state <= S_WRITE;
          end else if (r_wcnt == LAST_WAIT) begin
            r_din   <= '0;
            r_terr  <= 1'b1;
            r_w_en  <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end

        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_swap  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_SWAP;
          end else begin
            r_idx <= r_idx + 11'd1;
            if (r_y == LAST_Y) begin
              r_y  <= '0;
              r_py <= '0;
              r_px <= r_px + STEP;
            end else begin
              r_y  <= r_y + YW'(1);
              r_py <= r_py + STEP;
            end
            r_px_stb <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_SWAP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr    = r_idx;
  assign w_addr      = r_idx[9:0];
  assign w_mask      = r_idx[10];
  assign p_x         = r_px;
  assign p_y         = r_py;
  assign px_stb      = r_px_stb;
  assign w_en        = r_w_en;
  assign din         = r_din;
  assign swap_en     = r_swap;
  assign frame_done  = r_done;
  assign busy        = r_busy;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_frame_sched.sv
// tb_frame_sched -- self-checking bench for frame_sched.
//
// Behavioural model: the pixel sequence is derived from plain arithmetic
// (idx -> x = idx/ROWS, y = idx%ROWS), expected write data from the
// stimulus rules (threshold on the driven sum, colour ROM contents, stuck
// pixel) and expected per-pixel latency from the metaball delay plan.
module tb_frame_sched;

  localparam int unsigned ROWS    = 64;
  localparam int unsigned NPIX    = 2048;
  localparam logic [31:0] STEPV   = 32'h0000_8000;
  localparam logic [31:0] THRESHV = 32'h0000_8000;

  logic        clk;
  logic        rst;
  logic        frame_req;
  logic [2:0]  mb_vld;
  logic [31:0] sum;
  logic [11:0] colour;
  logic [10:0] rom_addr;
  logic        px_stb;
  logic [31:0] p_x;
  logic [31:0] p_y;
  logic        w_en;
  logic        w_mask;
  logic [9:0]  w_addr;
  logic [11:0] din;
  logic        swap_en;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  frame_sched #(
    .N_MB   (3),
    .COLS   (32),
    .ROWS   (64),
    .STEP   (32'h0000_8000),
    .THRESH (32'h0000_8000),
    .TIMEOUT(1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_req  (frame_req),
    .mb_vld     (mb_vld),
    .sum        (sum),
    .colour     (colour),
    .rom_addr   (rom_addr),
    .px_stb     (px_stb),
    .p_x        (p_x),
    .p_y        (p_y),
    .w_en       (w_en),
    .w_mask     (w_mask),
    .w_addr     (w_addr),
    .din        (din),
    .swap_en    (swap_en),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus configuration (changed only while the DUT is idle)
  int sum_mode  = 0;   // 0: sum = 0x8000; 1: odd idx 0x8000, even idx 0x7fff
  int col_mode  = 0;   // 0: colour = ABC; 1: colour = idx ^ 5A5
  int lat_idx   = -1;  // pixel whose valids are delayed
  int lat_val   = 0;   // extra cycles for that pixel
  int stuck_idx = -1;  // pixel with one valid stuck low

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_sum(input int idx);
    if (sum_mode != 0 && idx[0] == 1'b0) return 32'h0000_7fff;
    return 32'h0000_8000;
  endfunction

  function automatic logic [11:0] f_col(input int idx);
    if (col_mode != 0) return 12'(idx) ^ 12'h5A5;
    return 12'hABC;
  endfunction

  function automatic logic [11:0] exp_din(input int idx);
    if (idx == stuck_idx) return 12'h000;
    if (f_sum(idx) >= THRESHV) return f_col(idx);
    return 12'h000;
  endfunction

  // Cycles from px_stb to w_en for a pixel
  function automatic int exp_delta(input int idx);
    if (idx == stuck_idx) return 1 + 1024;
    if (idx == lat_idx) return 3 + lat_val;
    return 3;
  endfunction

  // Colour ROM (1-cycle latency) and sum driver
  initial begin : rom_drv
    logic [10:0] a_prev;
    a_prev = '0;
    colour = '0;
    sum    = '0;
    forever begin
      @(negedge clk);
      colour = f_col(int'(a_prev));
      a_prev = rom_addr;
      sum    = f_sum(int'(rom_addr));
    end
  end

  // Metaball model: valids stay stale-high through the first WAIT cycle,
  // then drop for delayed pixels and return after lat_val cycles.
  initial begin : mb_drv
    int phase;
    int cnt;
    int cur;
    bit stuck_on;
    phase = 0; cnt = 0; cur = 0; stuck_on = 1'b0;
    mb_vld = 3'b111;
    forever begin
      @(negedge clk);
      if (stuck_on && w_en) begin
        mb_vld   = 3'b111;
        stuck_on = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mb_vld = 3'b111;
      end
      if (phase == 2) begin
        phase = 0;
        if (cur == stuck_idx) begin
          mb_vld[1] = 1'b0;
          stuck_on  = 1'b1;
        end else if (cur == lat_idx && lat_val > 0) begin
          mb_vld = 3'b000;
          cnt    = lat_val;
        end
      end else if (phase == 1) begin
        phase = 2;
      end
      if (px_stb) begin
        phase = 1;
        cur   = int'(rom_addr);
      end
    end
  end

  // Model state and captures
  int cyc = 0;
  int m_stb = 0;
  int m_wr = 0;
  int frames_done = 0;
  int t_stb = 0;
  int t_first_stb = 0;
  int frame_len = 0;
  bit m_busy = 1'b0;
  bit m_terr = 1'b0;
  int          cap_delta [8];
  logic [11:0] cap_din   [8];
  logic [9:0]  cap_a0, cap_a1024;
  logic        cap_m0, cap_m1024;

  initial begin : compare
    logic r;
    int idx;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      cyc++;
      if (r) begin
        m_stb  = 0;
        m_wr   = 0;
        m_busy = 1'b0;
        m_terr = 1'b0;
      end else begin
        if (px_stb) begin
          chk("stb_after_write", 32'(m_stb), 32'(m_wr));
          chk("rom_addr", 32'(rom_addr), 32'(m_stb));
          chk("p_x", p_x, 32'(m_stb / ROWS) * STEPV);
          chk("p_y", p_y, 32'(m_stb % ROWS) * STEPV);
          if (m_stb == 0) t_first_stb = cyc;
          t_stb  = cyc;
          m_stb++;
          m_busy = 1'b1;
        end
        chk("busy", 32'(busy), 32'(m_busy));
        if (w_en) begin
          idx = m_wr;
          if (idx == stuck_idx) m_terr = 1'b1;
          chk("write_outstanding", 32'(m_stb), 32'(m_wr + 1));
          chk("w_addr", 32'(w_addr), 32'(idx % 1024));
          chk("w_mask", 32'(w_mask), 32'(idx / 1024));
          chk("din", 32'(din), 32'(exp_din(idx)));
          chk("stb_to_wen", 32'(cyc - t_stb), 32'(exp_delta(idx)));
          chk("timeout_err", 32'(timeout_err), 32'(m_terr));
          if (idx < 8) begin
            cap_delta[idx] = cyc - t_stb;
            cap_din[idx]   = din;
          end
          if (idx == 0) begin
            cap_a0 = w_addr; cap_m0 = w_mask;
          end
          if (idx == 1024) begin
            cap_a1024 = w_addr; cap_m1024 = w_mask;
          end
          m_wr++;
        end
        if (w_en || swap_en || frame_done) begin
          chk("wen_and_swap", 32'(w_en & swap_en), 32'd0);
          chk("done_eq_swap", 32'(frame_done), 32'(swap_en));
        end
        if (swap_en) begin
          chk("frame_writes", 32'(m_wr), 32'(NPIX));
          frame_len = cyc - t_first_stb + 1;
          frames_done++;
          m_stb  = 0;
          m_wr   = 0;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic pulse_req();
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int start;
    start = frames_done;
    for (int i = 0; i < budget && frames_done < start + n; i++) @(negedge clk);
    chk("frames_completed", 32'(frames_done - start), 32'(n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_px_stb"}, 32'(px_stb), 32'd0);
    chk({tag, "_w_en"}, 32'(w_en), 32'd0);
    chk({tag, "_swap_en"}, 32'(swap_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_p_x"}, p_x, 32'd0);
    chk({tag, "_p_y"}, p_y, 32'd0);
    chk({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    chk({tag, "_w_mask"}, 32'(w_mask), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
  endtask

  initial begin : stim
    int f0;
    rst       = 1'b1;
    frame_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A: all valid, sum at threshold, constant colour
    pulse_req();
    wait_frames(1, 9000);
    chk("A_first_waddr", 32'(cap_a0), 32'd0);
    chk("A_first_wmask", 32'(cap_m0), 32'd0);
    chk("A_first_din", 32'(cap_din[0]), 32'hABC);
    chk("A_w1024_addr", 32'(cap_a1024), 32'd0);
    chk("A_w1024_mask", 32'(cap_m1024), 32'd1);
    chk("A_stb_to_swap", 32'(frame_len), 32'd8193);
    chk("A_delta0", 32'(cap_delta[0]), 32'd3);
    repeat (5) @(negedge clk);

    // B: sum straddling the threshold, addressed colour, idx 3 valids late
    sum_mode = 1; col_mode = 1; lat_idx = 3; lat_val = 10;
    pulse_req();
    wait_frames(1, 9000);
    chk("B_din_idx2_below", 32'(cap_din[2]), 32'h000);
    chk("B_din_idx3_lit", 32'(cap_din[3]), 32'h5A6);
    chk("B_delta_idx2", 32'(cap_delta[2]), 32'd3);
    chk("B_delta_idx3", 32'(cap_delta[3]), 32'd13);
    chk("B_stb_to_swap", 32'(frame_len), 32'd8203);
    sum_mode = 0; col_mode = 0; lat_idx = -1; lat_val = 0;
    repeat (5) @(negedge clk);

    // C: one valid stuck low on idx 5
    stuck_idx = 5;
    chk("C_terr_before", 32'(timeout_err), 32'd0);
    pulse_req();
    wait_frames(1, 10000);
    chk("C_delta_idx5", 32'(cap_delta[5]), 32'd1025);
    chk("C_din_idx5", 32'(cap_din[5]), 32'h000);
    chk("C_din_idx4", 32'(cap_din[4]), 32'hABC);
    chk("C_terr_after", 32'(timeout_err), 32'd1);
    stuck_idx = -1;
    repeat (5) @(negedge clk);

    // D: three extra requests during a frame queue exactly one more frame
    f0 = frames_done;
    pulse_req();
    repeat (100) @(negedge clk);
    pulse_req();
    repeat (200) @(negedge clk);
    pulse_req();
    repeat (200) @(negedge clk);
    pulse_req();
    wait_frames(2, 18000);
    repeat (300) @(negedge clk);
    chk("D_frames", 32'(frames_done - f0), 32'd2);
    chk("D_idle_busy", 32'(busy), 32'd0);
    chk("D_no_new_stb", 32'(m_stb), 32'd0);

    // E: reset in the middle of the frame at idx 700
    f0 = frames_done;
    pulse_req();
    for (int i = 0; i < 4000 && m_stb < 701; i++) @(negedge clk);
    chk("E_reached_idx700", 32'(m_stb), 32'd701);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("E_no_swap", 32'(frames_done - f0), 32'd0);
    chk("E_idle_busy", 32'(busy), 32'd0);
    pulse_req();
    wait_frames(1, 9000);
    chk("E_restart_len", 32'(frame_len), 32'd8193);
    chk("E_restart_waddr0", 32'(cap_a0), 32'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Sequences one full-frame sweep of the shared metaball datapath.
- Walks the sample point (p_x, p_y) over every display pixel and strobes all metaballs per pixel.
- Waits for all of them to report valid, thresholds the summed field, and writes colour or black into the top/bottom frame buffers.
- Issues one buffer swap per completed frame.
- Sits between the movement strobe, the metaball array, the colour ROM and the two display buffers, and owns all buffer write traffic.

Parameters:
- N_MB, 3, number of metaball instances handshaken per pixel.
- COLS, 32, display columns (x).
- ROWS, 64, display rows (y).
- STEP, 32'h0000_8000, fixed-point increment of one pixel (15 fractional bits).
- THRESH, 32'h0000_8000, field sum at or above which a pixel is lit.
- TIMEOUT, 1024, maximum cycles to wait for all valids on one pixel.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_req  in  1  start-frame strobe (movement strobe).
- mb_vld  in  N_MB  per-metaball result valid.
- sum  in  32  sum of metaball outputs.
- colour  in  12  ROM colour for rom_addr, 1-cycle ROM latency.
- rom_addr  out  11  pixel index presented to the colour ROM.
- px_stb  out  1  start-calculation strobe to all metaballs.
- p_x  out  32  sample x (fixed point).
- p_y  out  32  sample y (fixed point).
- w_en  out  1  buffer write strobe.
- w_mask  out  1  0 = top buffer, 1 = bottom buffer.
- w_addr  out  10  buffer write address.
- din  out  12  buffer write data.
- swap_en  out  1  buffer swap strobe.
- busy  out  1  frame in progress.
- frame_done  out  1  end-of-frame pulse.
- timeout_err  out  1  sticky, set on any valid timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel index idx = 0; pending flag and wait counter cleared. Reset mid-frame aborts the frame immediately: no write, no swap.
- Pixel order: y inner, x outer. idx = x*ROWS + y, range 0..COLS*ROWS-1 (0..2047).
  - p_x = x*STEP, p_y = y*STEP.
  - rom_addr = idx.
  - w_addr = idx[9:0]; w_mask = idx[10], so the top buffer takes idx 0..1023.
- States:
  - IDLE: busy = 0. Moves to ISSUE when frame_req or pending is set; clears pending and zeroes idx, p_x, p_y.
  - ISSUE: px_stb = 1 for exactly one cycle, then WAIT.
  - WAIT: the first WAIT cycle ignores mb_vld, because valids fall one cycle after px_stb. From the second cycle on, when &mb_vld is true, go to WRITE.
    - The wait counter counts WAIT cycles. On reaching TIMEOUT, set timeout_err and go to WRITE with forced-black data.
  - WRITE: w_en = 1 for one cycle.
    - din = colour if sum >= THRESH (unsigned compare) and no timeout occurred; otherwise 0.
    - If idx is the last pixel, go to SWAP. Otherwise advance: y+1, wrapping to 0 with x+1; go to ISSUE.
  - SWAP: swap_en = 1 and frame_done = 1 for one cycle, then IDLE.
- busy = 1 in ISSUE, WAIT, WRITE and SWAP.
- Minimum per pixel is 4 cycles (ISSUE, 2×WAIT, WRITE). rom_addr is stable from ISSUE through WRITE, so colour is valid in WRITE.
- frame_req while busy sets pending (one deep). Further requests while pending is already set are dropped. A request in the SWAP cycle also sets pending.
- p_x/p_y arithmetic is 32-bit unsigned with no overflow for the default sizes. Max p_y = 32'h001f_8000; max p_x = 32'h000f_8000.
- w_en and swap_en are never high in the same cycle.
- px_stb is never issued while in WAIT.

Test Plan:
- Reset, then frame_req pulse with mb_vld tied high and sum = 32'h0000_8000, colour = 12'hABC:
  - 2048 writes, each with din = 12'hABC.
  - First write w_addr 0, w_mask 0; write 1024 has w_addr 0, w_mask 1.
  - Then one swap_en/frame_done pulse, with the first px_stb to swap_en taking 8193 cycles.
- sum = 32'h0000_7fff on all pixels -> every din = 0; the swap still occurs.
- mb_vld high before px_stb and dropping one cycle after -> no write before the fresh valid. A metaball delaying vld 10 cycles delays w_en exactly 10 cycles.
- One mb_vld bit stuck low for pixel idx 5 -> timeout_err set after 1024 WAIT cycles; idx 5 written with 0; the frame completes.
- Three frame_req pulses during a frame -> exactly one further frame starts after frame_done; the third request is dropped.
- rst asserted at idx 700 -> all outputs 0 next cycle, no swap_en. The next frame_req restarts at idx 0, p_x = p_y = 0.
